// File: rtl/sample_stream_deframer_pkg.sv
// Shared framing constants and FSM encoding for the FT2232H 2-byte sample link.
// Frame layout: byte0 = {SYNC_HI, s[13:7]}, byte1 = {SYNC_LO, s[6:0]}.
package sample_stream_deframer_pkg;

  localparam int   SAMPLE_W = 14;
  localparam int   HALF_W   = 7;
  localparam int   SYNC_BIT = 7;
  localparam logic SYNC_HI  = 1'b1;
  localparam logic SYNC_LO  = 1'b0;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_WAIT_LO = 1'b1
  } state_t;

  // Reassemble a sample from its two 7-bit halves.
  function automatic logic [SAMPLE_W-1:0] join_halves(input logic [HALF_W-1:0] hi,
                                                      input logic [HALF_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO. DEPTH must be a power of two (>= 2)
// so the pointers wrap naturally. Head data reads as zero while empty.
module sample_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; validity is tracked by level, so resetting it only costs area.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_stream_deframer.sv
// Receive-side deframer for the FT2232H sample link: rebuilds 14-bit DAC samples
// from byte pairs, resyncs on framing errors, drops stalled frames after a timeout,
// buffers samples in a FWFT FIFO and stretches errors onto an LED.
// Optional: define DEFRAMER_STATS_EN to add saturating error/overflow counters.
module sample_stream_deframer
  import sample_stream_deframer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ERR_HOLD    = 7200000
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  output logic [SAMPLE_W-1:0]           sample_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic                          led_rxerr_o
`ifdef DEFRAMER_STATS_EN
  ,
  output logic [15:0]                   frame_err_cnt_o,
  output logic [15:0]                   overflow_cnt_o
`endif
);

  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LED_W   = $clog2(ERR_HOLD + 1);

  state_t              state, state_next;
  logic [HALF_W-1:0]   hi, hi_next;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic                push;
  logic                err_evt;
  logic                ovf_evt;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LED_W-1:0]    led_cnt;

  // Frame recognition: next state, held high half, timeout timer, push and error strobes.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    hi_next    = hi;
    timer_next = timer;
    push       = 1'b0;
    err_evt    = 1'b0;
    case (state)
      ST_HUNT: begin
        if (rx_valid_i) begin
          if (rx_data_i[SYNC_BIT] == SYNC_HI) begin
            hi_next    = rx_data_i[HALF_W-1:0];
            timer_next = '0;
            state_next = ST_WAIT_LO;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      ST_WAIT_LO: begin
        if (rx_valid_i) begin
          if (rx_data_i[SYNC_BIT] == SYNC_LO) begin
            push       = 1'b1;
            state_next = ST_HUNT;
          end else begin
            // A second byte0 restarts the frame with the new high half.
            err_evt    = 1'b1;
            hi_next    = rx_data_i[HALF_W-1:0];
            timer_next = '0;
          end
        end else if (timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
          err_evt    = 1'b1;
          state_next = ST_HUNT;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
    endcase
  end

  // A completed sample is lost only when the FIFO is full and the head is not leaving.
  assign ovf_evt = push && fifo_full && !sample_ready_i;

  // Frame FSM registers and registered error pulses.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= ST_HUNT;
      hi          <= '0;
      timer       <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state       <= state_next;
      hi          <= hi_next;
      timer       <= timer_next;
      frame_err_o <= err_evt;
      overflow_o  <= ovf_evt;
    end
  end

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .push      (push),
    .push_data (join_halves(hi, rx_data_i[HALF_W-1:0])),
    .pop       (sample_ready_i),
    .pop_data  (sample_o),
    .level     (fifo_level_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sample_valid_o = !fifo_empty;

  // LED stretch: reload on any error pulse, otherwise count down to zero.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      led_cnt <= '0;
    end else if (frame_err_o || overflow_o) begin
      led_cnt <= LED_W'(ERR_HOLD);
    end else if (led_cnt != '0) begin
      led_cnt <= led_cnt - LED_W'(1);
    end
  end

  assign led_rxerr_o = (led_cnt != '0);

`ifdef DEFRAMER_STATS_EN
  // Saturating event counters for link diagnostics.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      frame_err_cnt_o <= '0;
      overflow_cnt_o  <= '0;
    end else begin
      if (frame_err_o && (frame_err_cnt_o != 16'hFFFF)) frame_err_cnt_o <= frame_err_cnt_o + 16'd1;
      if (overflow_o  && (overflow_cnt_o  != 16'hFFFF)) overflow_cnt_o  <= overflow_cnt_o  + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_stream_deframer.sv
// Directed self-checking bench for sample_stream_deframer.
// Builds with or without DEFRAMER_STATS_EN.
module tb_sample_stream_deframer;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;
  localparam int HOLD  = 200;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [13:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        frame_err;
  logic        overflow;
  logic        led_rxerr;
`ifdef DEFRAMER_STATS_EN
  logic [15:0] frame_err_cnt;
  logic [15:0] overflow_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  logic [13:0] got_q [$];

  always #5 clk = ~clk;

  sample_stream_deframer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO),
    .ERR_HOLD    (HOLD)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .fifo_level_o   (fifo_level),
    .frame_err_o    (frame_err),
    .overflow_o     (overflow),
    .led_rxerr_o    (led_rxerr)
`ifdef DEFRAMER_STATS_EN
    ,
    .frame_err_cnt_o (frame_err_cnt),
    .overflow_cnt_o  (overflow_cnt)
`endif
  );

  // Pulse counters and record of every sample the consumer takes.
  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (overflow)  ovf_seen++;
    if (sample_valid && sample_ready) got_q.push_back(sample);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one cycle; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    int o0;
    logic [13:0] exp5 [5];

    reset_ni     = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    sample_ready = 1'b1;
    #12;
    check("rst_valid", sample_valid, 0);
    check("rst_sample", sample, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_led", led_rxerr, 0);
    @(negedge clk);
    reset_ni = 1'b1;

    // 1: clean frame, one-cycle latency to the FIFO head
    e0 = err_seen;
    send_byte(8'hAA);
    send_byte(8'h55);
    check("t1_valid_n1", sample_valid, 1);
    check("t1_sample_n1", sample, 14'h1555);
    idle(2);
    check("t1_pop_cnt", got_q.size(), 1);
    if (got_q.size() > 0) check("t1_pop_val", got_q[0], 14'h1555);
    check("t1_no_ferr", err_seen - e0, 0);
    check("t1_no_led", led_rxerr, 0);
    got_q.delete();

    // 2: stray low byte in HUNT, then a good frame
    e0 = err_seen;
    send_byte(8'h05);
    send_byte(8'h81);
    send_byte(8'h02);
    idle(2);
    check("t2_ferr", err_seen - e0, 1);
    check("t2_pop_cnt", got_q.size(), 1);
    if (got_q.size() > 0) check("t2_pop_val", got_q[0], 14'h0082);
    check("t2_led", led_rxerr, 1);
    got_q.delete();

    // 3: second byte0 resyncs
    e0 = err_seen;
    send_byte(8'h81);
    send_byte(8'h83);
    send_byte(8'h04);
    idle(2);
    check("t3_ferr", err_seen - e0, 1);
    check("t3_pop_cnt", got_q.size(), 1);
    if (got_q.size() > 0) check("t3_pop_val", got_q[0], 14'h0184);
    got_q.delete();

    // 4: timeout boundary, then an orphan byte1
    e0 = err_seen;
    send_byte(8'h81);
    idle(TMO - 1);
    check("t4_no_early_to", err_seen - e0, 0);
    check("t4_ferr_pre", frame_err, 0);
    idle(1);
    check("t4_ferr_at_to", frame_err, 1);
    send_byte(8'h04);
    idle(2);
    check("t4_ferr_total", err_seen - e0, 2);
    check("t4_no_sample", got_q.size(), 0);
    check("t4_empty", sample_valid, 0);

    // 5: fill past capacity, then push and pop together while full
    sample_ready = 1'b0;
    o0 = ovf_seen;
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'h80 | 8'(k));
      send_byte(8'(k));
    end
    idle(2);
    check("t5_level_full", fifo_level, 4);
    check("t5_ovf", ovf_seen - o0, 1);
    check("t5_head", sample, 14'h0081);
    check("t5_no_pop", got_q.size(), 0);
    send_byte(8'h86);
    @(posedge clk);
    #1;
    rx_data      = 8'h06;
    rx_valid     = 1'b1;
    sample_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_valid     = 1'b0;
    sample_ready = 1'b0;
    idle(2);
    check("t5_level_same", fifo_level, 4);
    check("t5_ovf_same", ovf_seen - o0, 1);
    check("t5_head_next", sample, 14'h0102);
    sample_ready = 1'b1;
    idle(6);
    sample_ready = 1'b0;
    exp5 = '{14'h0081, 14'h0102, 14'h0183, 14'h0204, 14'h0306};
    check("t5_drain_cnt", got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) check($sformatf("t5_drain_%0d", i), got_q[i], exp5[i]);
    check("t5_level_empty", fifo_level, 0);
    got_q.delete();

    // 6: reset mid-frame with a sample buffered
    check("t6_err_total", err_seen, 4);
`ifdef DEFRAMER_STATS_EN
    check("t6_ferr_cnt", frame_err_cnt, 4);
    check("t6_ovf_cnt", overflow_cnt, 1);
`endif
    send_byte(8'h8A);
    send_byte(8'h0B);
    send_byte(8'h81);
    check("t6_pre_valid", sample_valid, 1);
    check("t6_pre_led", led_rxerr, 1);
    reset_ni = 1'b0;
    #1;
    check("t6_rst_valid", sample_valid, 0);
    check("t6_rst_sample", sample, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_led", led_rxerr, 0);
`ifdef DEFRAMER_STATS_EN
    check("t6_rst_ferr_cnt", frame_err_cnt, 0);
    check("t6_rst_ovf_cnt", overflow_cnt, 0);
`endif
    idle(2);
    @(negedge clk);
    reset_ni = 1'b1;
    e0 = err_seen;
    sample_ready = 1'b1;
    send_byte(8'h02);
    idle(2);
    check("t6_ferr", err_seen - e0, 1);
    check("t6_no_sample", got_q.size(), 0);
    check("t6_empty", sample_valid, 0);
`ifdef DEFRAMER_STATS_EN
    check("t6_post_ferr_cnt", frame_err_cnt, 1);
    check("t6_post_ovf_cnt", overflow_cnt, 0);
`endif
    check("t6_led_on", led_rxerr, 1);
    idle(HOLD + 3);
    check("t6_led_off", led_rxerr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
